// File: rtl/mac_accumulator.sv
// Signed multiply / multiply-accumulate unit with a sticky overflow flag and an accumulation counter.
// Optional build macro MAC_SAT_EN: RESULT saturates to the DW signed range instead of wrapping.
module mac_accumulator #(
  parameter int DW   = 32,
  parameter int ACCW = 64,
  parameter int CNTW = 16
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [DW-1:0]   A,
  input  logic [DW-1:0]   B,
  input  logic            MAC_EN,
  input  logic            MAC_RST,
  input  logic            mul_mac,
  output logic [DW-1:0]   RESULT,
  output logic            ACC_OVF,
  output logic [CNTW-1:0] MAC_CNT,
  output logic            BUSY
);

  logic signed [2*DW-1:0] prod;
  logic [ACCW-1:0]        prod_ext;
  logic [ACCW-1:0]        sum;
  logic [ACCW-1:0]        acc;
  logic [CNTW-1:0]        mac_cnt;
  logic                   acc_ovf;
  logic                   en_d;
  logic                   upd;

  // True when x cannot be represented as a DW-bit signed value.
  function automatic logic out_of_range(input logic [ACCW-1:0] x);
    return !((&x[ACCW-1:DW-1]) || !(|x[ACCW-1:DW-1]));
  endfunction

  function automatic logic [DW-1:0] fit(input logic [ACCW-1:0] x);
`ifdef MAC_SAT_EN
    if (out_of_range(x))
      return x[ACCW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
`endif
    return x[DW-1:0];
  endfunction

  assign prod     = $signed(A) * $signed(B);
  assign prod_ext = ACCW'(prod);
  assign sum      = acc + prod_ext;

  // Only the first cycle of each MAC_EN assertion updates state, so a stalled FSM cannot double-count.
  assign upd = MAC_EN & ~en_d;

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    RESULT = fit(acc);
    if (MAC_EN) begin
      if (MAC_RST) RESULT = fit(prod_ext);
      else         RESULT = fit(sum);
    end else if (mul_mac) begin
      RESULT = prod[DW-1:0];
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      acc     <= '0;
      en_d    <= 1'b0;
      mac_cnt <= '0;
      acc_ovf <= 1'b0;
    end else begin
      en_d <= MAC_EN;
      if (upd) begin
        if (MAC_RST) begin
          acc     <= prod_ext;
          mac_cnt <= CNTW'(1);
          acc_ovf <= out_of_range(prod_ext);
        end else begin
          acc <= sum;
          if (mac_cnt != '1) mac_cnt <= mac_cnt + 1'b1;
          acc_ovf <= acc_ovf | out_of_range(sum);
        end
      end
    end
  end

  assign ACC_OVF = acc_ovf;
  assign MAC_CNT = mac_cnt;
  assign BUSY    = 1'b0;

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed self-checking bench for mac_accumulator; define MAC_SAT_EN for the saturating build.
module tb_mac_accumulator;

  localparam int DW = 32;
  localparam int CNTW = 16;

  logic            CLK;
  logic            RESET;
  logic [DW-1:0]   A, B;
  logic            MAC_EN, MAC_RST, mul_mac;
  logic [DW-1:0]   RESULT;
  logic            ACC_OVF;
  logic [CNTW-1:0] MAC_CNT;
  logic            BUSY;

  int tests_run = 0;
  int tests_failed = 0;

  mac_accumulator #(.DW(DW), .ACCW(64), .CNTW(CNTW)) dut (
    .CLK(CLK), .RESET(RESET), .A(A), .B(B),
    .MAC_EN(MAC_EN), .MAC_RST(MAC_RST), .mul_mac(mul_mac),
    .RESULT(RESULT), .ACC_OVF(ACC_OVF), .MAC_CNT(MAC_CNT), .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Drive inputs 1 time unit after a rising edge; outputs are sampled 2 units later.
  task automatic drive(input logic en, input logic rst, input logic mul,
                       input logic [DW-1:0] a, input logic [DW-1:0] b);
    @(posedge CLK);
    #1;
    MAC_EN = en; MAC_RST = rst; mul_mac = mul; A = a; B = b;
    #2;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    idle();
    RESET = 1'b1;
    idle();
    tests_run++;
    if (RESULT !== 32'd0) begin tests_failed++; $display("FAIL reset_result: got %h want %h", RESULT, 32'd0); end
    tests_run++;
    if (MAC_CNT !== 16'd0) begin tests_failed++; $display("FAIL reset_cnt: got %0d want 0", MAC_CNT); end
    tests_run++;
    if (ACC_OVF !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf: got %b want 0", ACC_OVF); end
    tests_run++;
    if (BUSY !== 1'b0) begin tests_failed++; $display("FAIL busy: got %b want 0", BUSY); end
  endtask

  task automatic test_mul();
    drive(1'b0, 1'b0, 1'b1, 32'd7, -32'sd3);
    tests_run++;
    if (RESULT !== 32'hFFFF_FFEB) begin tests_failed++; $display("FAIL mul_result: got %h want %h", RESULT, 32'hFFFF_FFEB); end
    idle();
    tests_run++;
    if (RESULT !== 32'd0 || MAC_CNT !== 16'd0) begin
      tests_failed++; $display("FAIL mul_no_state: got result %h cnt %0d want 0 0", RESULT, MAC_CNT);
    end
  endtask

  task automatic test_mac();
    drive(1'b1, 1'b1, 1'b0, 32'd5, 32'd6);
    tests_run++;
    if (RESULT !== 32'd30) begin tests_failed++; $display("FAIL macfirst_result: got %0d want 30", RESULT); end
    idle();
    tests_run++;
    if (MAC_CNT !== 16'd1) begin tests_failed++; $display("FAIL macfirst_cnt: got %0d want 1", MAC_CNT); end
    drive(1'b1, 1'b0, 1'b0, 32'd2, -32'sd4);
    tests_run++;
    if (RESULT !== 32'd22) begin tests_failed++; $display("FAIL mac_result: got %0d want 22", RESULT); end
    idle();
    tests_run++;
    if (MAC_CNT !== 16'd2 || RESULT !== 32'd22) begin
      tests_failed++; $display("FAIL mac_state: got cnt %0d acc %0d want 2 22", MAC_CNT, RESULT);
    end
    // plain multiply while a sum is live must leave it untouched
    drive(1'b0, 1'b0, 1'b1, 32'd3, 32'd3);
    tests_run++;
    if (RESULT !== 32'd9) begin tests_failed++; $display("FAIL mul_live_result: got %0d want 9", RESULT); end
    // MAC_RST alone is ignored
    drive(1'b0, 1'b1, 1'b0, 32'd100, 32'd100);
    tests_run++;
    if (RESULT !== 32'd22) begin tests_failed++; $display("FAIL rst_alone_result: got %0d want 22", RESULT); end
    idle();
    tests_run++;
    if (MAC_CNT !== 16'd2 || RESULT !== 32'd22) begin
      tests_failed++; $display("FAIL mul_keeps_acc: got cnt %0d acc %0d want 2 22", MAC_CNT, RESULT);
    end
    // MAC_EN has priority over mul_mac: 22 + 3*4 = 34
    drive(1'b1, 1'b0, 1'b1, 32'd3, 32'd4);
    tests_run++;
    if (RESULT !== 32'd34) begin tests_failed++; $display("FAIL priority_result: got %0d want 34", RESULT); end
    idle();
    tests_run++;
    if (MAC_CNT !== 16'd3) begin tests_failed++; $display("FAIL priority_cnt: got %0d want 3", MAC_CNT); end
  endtask

  task automatic test_hold();
    drive(1'b1, 1'b1, 1'b0, 32'd0, 32'd1);
    idle();
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 32'd1, 32'd1);
    idle();
    tests_run++;
    if (RESULT !== 32'd1 || MAC_CNT !== 16'd1) begin
      tests_failed++; $display("FAIL hold_first: got acc %0d cnt %0d want 1 1", RESULT, MAC_CNT);
    end
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 32'd1, 32'd1);
    idle();
    tests_run++;
    if (RESULT !== 32'd2 || MAC_CNT !== 16'd2) begin
      tests_failed++; $display("FAIL hold_mac: got acc %0d cnt %0d want 2 2", RESULT, MAC_CNT);
    end
  endtask

  task automatic test_overflow();
    logic [DW-1:0] exp_first, exp_over;
`ifdef MAC_SAT_EN
    exp_first = 32'h7FFF_FFFF;
    exp_over  = 32'h7FFF_FFFF;
`else
    exp_first = 32'h0000_0000;
    exp_over  = 32'h8000_0000;
`endif
    drive(1'b1, 1'b1, 1'b0, 32'h4000_0000, 32'd4);
    tests_run++;
    if (RESULT !== exp_first) begin tests_failed++; $display("FAIL ovf_first_result: got %h want %h", RESULT, exp_first); end
    idle();
    drive(1'b1, 1'b0, 1'b0, 32'h4000_0000, 32'd2);
    tests_run++;
    if (RESULT !== exp_over) begin tests_failed++; $display("FAIL ovf_result: got %h want %h", RESULT, exp_over); end
    idle();
    tests_run++;
    if (ACC_OVF !== 1'b1 || RESULT !== exp_over) begin
      tests_failed++; $display("FAIL ovf_state: got ovf %b acc %h want 1 %h", ACC_OVF, RESULT, exp_over);
    end
    // 0x1_8000_0000 - 0x1_8000_0000 = 0: sum returns in range, flag stays sticky
    drive(1'b1, 1'b0, 1'b0, 32'h4000_0000, -32'sd6);
    idle();
    tests_run++;
    if (RESULT !== 32'd0 || ACC_OVF !== 1'b1) begin
      tests_failed++; $display("FAIL ovf_sticky: got acc %h ovf %b want 0 1", RESULT, ACC_OVF);
    end
    drive(1'b1, 1'b1, 1'b0, 32'd1, 32'd1);
    idle();
    tests_run++;
    if (ACC_OVF !== 1'b0 || RESULT !== 32'd1) begin
      tests_failed++; $display("FAIL ovf_clear: got ovf %b acc %h want 0 1", ACC_OVF, RESULT);
    end
  endtask

  task automatic test_reset_vs_mac();
    @(posedge CLK);
    #1;
    RESET = 1'b0; MAC_EN = 1'b1; MAC_RST = 1'b1; mul_mac = 1'b0; A = 32'd9; B = 32'd9;
    @(posedge CLK);
    #1;
    RESET = 1'b1; MAC_EN = 1'b0; MAC_RST = 1'b0; A = '0; B = '0;
    #2;
    tests_run++;
    if (RESULT !== 32'd0 || MAC_CNT !== 16'd0 || ACC_OVF !== 1'b0) begin
      tests_failed++; $display("FAIL reset_wins: got acc %h cnt %0d ovf %b want 0 0 0", RESULT, MAC_CNT, ACC_OVF);
    end
    // mac with no prior macFirst accumulates onto the reset value
    drive(1'b1, 1'b0, 1'b0, 32'd2, 32'd3);
    idle();
    tests_run++;
    if (RESULT !== 32'd6 || MAC_CNT !== 16'd1) begin
      tests_failed++; $display("FAIL mac_after_reset: got acc %0d cnt %0d want 6 1", RESULT, MAC_CNT);
    end
  endtask

  initial begin
    RESET = 1'b0; MAC_EN = 1'b0; MAC_RST = 1'b0; mul_mac = 1'b0; A = '0; B = '0;
    test_reset();
    test_mul();
    test_mac();
    test_hold();
    test_overflow();
    test_reset_vs_mac();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
